// File: rtl/fifo_pkg.sv
// Shared helpers for the narrow-to-wide FIFO.
// Lane-count width and lane bit-position functions.
package fifo_pkg;

  function automatic int lanes_w(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

  function automatic int lane_lsb(
    input int idx,
    input int ratio,
    input int width,
    input bit big_endian
  );
    return big_endian ? (ratio - 1 - idx) * width
                      : idx * width;
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Single-clock first-word-fall-through FIFO.
// Ports: CLK, RST_N (async low), push/din, pop/dout,
//   full, empty, size (words stored).
module fifo_sync_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     size
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign size  = wr_ptr - rd_ptr;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head word is visible combinationally; zero when nothing stored.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_narrow_to_wide.sv
// Packs RATIO narrow lanes into wide words and buffers them.
// Ports: CLK, RST_N; WRITE/DATA_IN/FLUSH in, FULL/OVERFLOW out;
//   READ in, DATA_OUT/LANES_OUT/EMPTY/SIZE out (FWFT).
module fifo_narrow_to_wide
  import fifo_pkg::*;
#(
  parameter int                  IN_WIDTH   = 8,
  parameter int                  RATIO      = 4,
  parameter int                  DEPTH      = 1024,
  parameter bit                  BIG_ENDIAN = 1'b0,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         WRITE,
  input  logic [IN_WIDTH-1:0]          DATA_IN,
  input  logic                         FLUSH,
  output logic                         FULL,
  output logic                         OVERFLOW,
  input  logic                         READ,
  output logic [IN_WIDTH*RATIO-1:0]    DATA_OUT,
  output logic [$clog2(RATIO):0]       LANES_OUT,
  output logic                         EMPTY,
  output logic [$clog2(DEPTH):0]       SIZE
);

  localparam int OW = IN_WIDTH * RATIO;
  localparam int LW = lanes_w(RATIO);
  localparam int CW = LW - 1;
  localparam int SW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  // Reset deassertion is brought into the CLK domain.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  logic [CW-1:0] lane_cnt;
  logic [OW-1:0] asm_buf;
  logic          hold_valid;
  logic [OW-1:0] hold_data;
  logic [LW-1:0] hold_lanes;
  logic          overflow;

  logic          fifo_full;
  logic          fifo_empty;
  logic [OW+LW-1:0] fifo_dout;
  logic [SW-1:0] fifo_size;

  logic          full_int;
  logic          accept;
  logic          complete;
  logic          flush_ok;
  logic          load_hold;
  logic          drain;
  logic [LW-1:0] filled;
  logic [OW-1:0] asm_next;
  logic [OW-1:0] word_next;

  assign full_int  = hold_valid & fifo_full;
  assign accept    = WRITE & ~full_int;
  assign complete  = accept & (lane_cnt == LAST);
  assign flush_ok  = FLUSH & ~full_int &
                     ((lane_cnt != '0) | accept);
  assign load_hold = complete | flush_ok;
  assign drain     = hold_valid & ~fifo_full;

  // Lanes filled including any written this cycle; equals RATIO
  // on completion, so one path serves both full and flushed words.
  assign filled = LW'(lane_cnt) + LW'(accept);

  always_comb begin
    asm_next = asm_buf;
    if (accept) begin
      asm_next[lane_lsb(int'(lane_cnt), RATIO, IN_WIDTH,
                        BIG_ENDIAN) +: IN_WIDTH] = DATA_IN;
    end
  end

  always_comb begin
    word_next = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(filled)) begin
        word_next[lane_lsb(i, RATIO, IN_WIDTH, BIG_ENDIAN)
                  +: IN_WIDTH] =
          asm_next[lane_lsb(i, RATIO, IN_WIDTH, BIG_ENDIAN)
                   +: IN_WIDTH];
      end else begin
        word_next[lane_lsb(i, RATIO, IN_WIDTH, BIG_ENDIAN)
                  +: IN_WIDTH] = PAD_VALUE;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt   <= '0;
      asm_buf    <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_lanes <= '0;
      overflow   <= 1'b0;
    end else begin
      if (WRITE & full_int) begin
        overflow <= 1'b1;
      end

      if (load_hold) begin
        lane_cnt <= '0;
        asm_buf  <= '0;
      end else if (accept) begin
        lane_cnt <= lane_cnt + 1'b1;
        asm_buf  <= asm_next;
      end

      // Hold can refill on the same edge it drains.
      if (load_hold) begin
        hold_valid <= 1'b1;
        hold_data  <= word_next;
        hold_lanes <= filled;
      end else if (drain) begin
        hold_valid <= 1'b0;
      end
    end
  end

  fifo_sync_mem #(
    .WIDTH (OW + LW),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK   (CLK),
    .RST_N (rst_n),
    .push  (drain),
    .din   ({hold_lanes, hold_data}),
    .pop   (READ),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .size  (fifo_size)
  );

  assign FULL      = full_int;
  assign OVERFLOW  = overflow;
  assign EMPTY     = fifo_empty;
  assign SIZE      = fifo_size;
  assign DATA_OUT  = fifo_dout[OW-1:0];
  assign LANES_OUT = fifo_dout[OW +: LW];

endmodule

// File: doc/fifo_narrow_to_wide.md
Name: fifo_narrow_to_wide

Overview:
Parametrised width-converting FIFO. Packs RATIO narrow input words of IN_WIDTH bits into one IN_WIDTH*RATIO output word and buffers up to DEPTH wide words. Lane order is selectable. An explicit FLUSH emits a padded partial word together with its valid-lane count. Sits between byte/word-oriented receivers (serial links, TDC/trigger data) and 32/64-bit readout paths.

Parameters:
IN_WIDTH, 8, width of one input lane in bits.
RATIO, 4, input lanes per output word (>=2). OUT_WIDTH = IN_WIDTH*RATIO.
DEPTH, 1024, output FIFO depth in wide words (power of two).
BIG_ENDIAN, 0, lane order: 0 = first lane at DATA_OUT[IN_WIDTH-1:0]; 1 = first lane at MSBs.
PAD_VALUE, 0, IN_WIDTH-bit fill value for unfilled lanes on FLUSH.

Ports:
CLK  in  1  clock; all logic on rising edge.
RST_N  in  1  asynchronous, active-low reset.
WRITE  in  1  DATA_IN valid; accepted when ~FULL.
DATA_IN  in  IN_WIDTH  input lane.
FLUSH  in  1  close the current partial word; honoured when ~FULL.
FULL  out  1  writer back-pressure.
OVERFLOW  out  1  sticky: a WRITE arrived while FULL.
READ  in  1  pop the head word; ignored when EMPTY.
DATA_OUT  out  OUT_WIDTH  head word (first-word-fall-through).
LANES_OUT  out  $clog2(RATIO)+1  number of valid lanes in DATA_OUT (1..RATIO).
EMPTY  out  1  no word available.
SIZE  out  $clog2(DEPTH)+1  words stored in the output FIFO (hold register excluded).

Behaviour:
- Reset (RST_N low, async): lane_cnt=0, assembly buffer=0, hold_valid=0, pointers=0. Outputs: FULL=0, OVERFLOW=0, EMPTY=1, DATA_OUT=0, LANES_OUT=0, SIZE=0. Reset mid-word discards partial data. Deassertion is synchronised to CLK inside the block.
- accept = WRITE & ~FULL. Lane index lane_cnt (0..RATIO-1) selects the slot; lane_cnt increments, wrapping RATIO-1 -> 0.
- Word completion, registered on the edge:
  - accept with lane_cnt==RATIO-1 loads the hold register with the assembled word, LANES=RATIO.
  - FLUSH & ~FULL with (lane_cnt!=0 or accept) loads hold with unfilled lanes = PAD_VALUE and LANES = filled lanes, including a lane written in the same cycle.
  - FLUSH with nothing buffered is a no-op. FLUSH coinciding with the completing lane yields exactly one word with LANES=RATIO.
- Hold drain: when hold_valid & ~fifo_full, hold is pushed into the output FIFO on that edge. A new completed word may load hold on the same edge.
- FULL = hold_valid & fifo_full, combinational from registers. It therefore asserts only when hold is occupied and the FIFO is full.
- A write while FULL is dropped and sets OVERFLOW; OVERFLOW clears only on reset. A FLUSH while FULL is ignored.
- Read: READ & ~EMPTY pops. DATA_OUT/LANES_OUT show the next word one cycle later, or EMPTY rises.
- Push and pop in the same cycle: SIZE unchanged. A pop frees space, so a held word drains on the following edge.
- Throughput: one input lane per cycle sustained while the FIFO is not full. Latency from the accept of the last lane to EMPTY falling is 2 cycles (hold, then FIFO).
- Pointers are $clog2(DEPTH)+1 bits with wrap bit; full/empty are derived from pointer compare; SIZE = wr_ptr - rd_ptr.

Decomposition:
- Package fifo_pkg: lane-count width function, and BIG_ENDIAN lane-position function lane_lsb(idx).
- Sub-module fifo_sync_mem: single-clock FWFT FIFO (WIDTH, DEPTH) with async active-low reset, full/empty/size. It stores {LANES, data}.
- Top level holds the lane counter, assembly buffer, hold register, FLUSH logic and OVERFLOW.

Test Plan:
1. IN_WIDTH=8, RATIO=4, BIG_ENDIAN=0: write 0x11,0x22,0x33,0x44 -> EMPTY falls 2 cycles after the last write; DATA_OUT=0x44332211, LANES_OUT=4. Same with BIG_ENDIAN=1 -> 0x11223344.
2. Write 0xAA,0xBB then FLUSH (PAD_VALUE=0) -> DATA_OUT=0x0000BBAA, LANES_OUT=2. FLUSH with lane_cnt=0 -> SIZE unchanged.
3. FLUSH in the same cycle as the 4th lane 0x44 after 0x11,0x22,0x33 -> one word 0x44332211, LANES_OUT=4, SIZE=1.
4. DEPTH=4, no reads: 20 writes -> SIZE=4, FULL=1 after the 20th. 21st write is dropped and OVERFLOW=1. One READ -> FULL=0 one cycle later, SIZE returns to 4, and words pop in write order.
5. RST_N low for one cycle after 2 lanes -> EMPTY=1, SIZE=0, OVERFLOW=0. Next 4 writes 0x01..0x04 -> 0x04030201 only.
6. Continuous writes with READ held high at DEPTH=4 -> FULL never asserts, no word lost, SIZE <= 1.
